// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back arbiter: requester
// indices and the packed request payload.
package wb_pkg;

  localparam int WB_NREQ = 3;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_FPU = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic        isf;
    logic [31:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back request bundle between the execution units and the arbiter.
// Slice i of each vector belongs to requester i.
interface wb_arbiter_if #(
  parameter int NREQ = 3
);

  logic [NREQ-1:0]    req_valid;
  logic [5*NREQ-1:0]  req_rd;
  logic [NREQ-1:0]    req_isf;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  modport master (
    output req_valid, req_rd, req_isf, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_rd, req_isf, req_data,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requesting index at or after ptr,
// and moves ptr just past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt;
  int            idx;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    gnt = '0;
    nxt = ptr;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        nxt      = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= nxt;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin selection among execution units feeding a
// registered single write port of the integer/float register file.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ = WB_NREQ,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  wb_arbiter_if.slave     bus,
  input  logic            hold,
  output logic            RegWrite,
  output logic [4:0]      WriteReg,
  output logic [31:0]     WriteData,
  output logic            writef,
  output logic [CNTW-1:0] contention
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic is_x0(input wb_req_t r);
    return (r.rd == 5'd0) && !r.isf;
  endfunction

  logic [NREQ-1:0] cand_p0;
  logic [NREQ-1:0] gnt_p0;
  logic            vld_p0;
  wb_req_t         sel_p0;
  logic            busy_p0;

  // Stage 0: combinational grant; nothing is offered while frozen or in reset.
  assign cand_p0       = bus.req_valid & {NREQ{~hold & rst}};
  assign vld_p0        = |gnt_p0;
  assign bus.req_ready = gnt_p0;
  assign busy_p0       = !hold && ($countones(bus.req_valid) >= 2);

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (cand_p0),
    .advance (vld_p0),
    .gnt     (gnt_p0)
  );

  always_comb begin
    sel_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_p0[i]) begin
        sel_p0 = {bus.req_rd[5*i +: 5], bus.req_isf[i], bus.req_data[32*i +: 32]};
      end
    end
  end

  // Stage 1: register-file write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      writef    <= 1'b0;
    end else begin
      RegWrite <= vld_p0 && !is_x0(sel_p0);
      if (vld_p0) begin
        WriteReg  <= sel_p0.rd;
        WriteData <= sel_p0.data;
        writef    <= sel_p0.isf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      contention <= '0;
    end else if (busy_p0) begin
      contention <= sat_inc(contention);
    end
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the core's shared integer/float register file. It accepts write-back requests from up to `NREQ` execution units (ALU, load/store unit, FPU) over valid/ready handshakes. Each cycle it grants one request by round-robin and drives the register file's single write port from a registered stage. It sits between the execute/memory units and the register file, and owns the file's `RegWrite`/`WriteReg`/`WriteData`/`writef` inputs.

## Interface
Parameters:
- `NREQ`, default 3: number of requesters. Index 0 = ALU, 1 = LSU, 2 = FPU.
- `CNTW`, default 16: width of the contention counter.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  NREQ  requester i has a write-back pending.
- `req_rd`  in  5*NREQ  destination register, slice i = bits [5i+4:5i].
- `req_isf`  in  NREQ  destination is the float file.
- `req_data`  in  32*NREQ  write data, slice i = bits [32i+31:32i].
- `req_ready`  out  NREQ  one-hot or zero; the request is accepted on an edge where valid&ready.
- `hold`  in  1  pipeline freeze; no grant while high.
- `RegWrite`  out  1  register-file write enable.
- `WriteReg`  out  5  register-file write address.
- `WriteData`  out  32  register-file write data.
- `writef`  out  1  selects the float file.
- `contention`  out  CNTW  saturating count of cycles with ≥2 valid requests while `hold` is low.

## Operation
- Grant selection:
  - Candidate set = `req_valid` when `hold`=0; otherwise empty.
  - Pick the first set bit at or after `ptr`, wrapping modulo NREQ.
  - `req_ready` is combinational from `req_valid`, `ptr` and `hold`. It is one-hot on the granted index, or all zero.
- Pointer update:
  - On an accept of index g, `ptr` ← (g+1) mod NREQ.
  - With no accept, `ptr` is unchanged.
  - Reset value of `ptr` is 0.
- Output stage, on every edge:
  - On accept: `RegWrite` ← 1, `WriteReg` ← rd_g, `WriteData` ← data_g, `writef` ← isf_g.
  - Otherwise `RegWrite` ← 0. `WriteReg`, `WriteData` and `writef` hold their previous values.
- Integer x0 suppression: an accepted request with rd=0 and isf=0 is consumed (ready asserted), but `RegWrite` ← 0. Float f0 is written normally.
- Contention counter: increments when popcount(`req_valid`) ≥ 2 and `hold`=0. It saturates at 2^CNTW−1 and never wraps.
- Ordering:
  - Writes from different requesters to the same register are committed in grant order.
  - Program-order correctness across units is the issuing stage's responsibility, not this block's.
- Requester rule: once valid, a requester keeps valid, rd, isf and data stable until accepted. The arbiter does not check this.

## Timing
- Reset (`rst`=0, asynchronous) values:
  - `RegWrite`=0, `WriteReg`=0, `WriteData`=0, `writef`=0.
  - `ptr`=0, `contention`=0.
  - `req_ready` = 0 while `rst` is low.
- Reset asserted mid-operation: any pending output write is dropped, regardless of clock.
- Latency:
  - Accept at edge k → `RegWrite` high during cycle k..k+1.
  - The register file captures the write at edge k+1.
  - Throughput is one write per cycle.
- `hold` high: `req_ready`=0 in that cycle. A write already in the output stage still completes, because `RegWrite` falls at the next edge.
- `hold` falling: arbitration resumes in the same cycle using the unchanged `ptr`.
- Single requester continuously valid: it is accepted every cycle. `ptr` moves past it each time and wraps back.
- All NREQ valid continuously: grants rotate 0,1,2,0,… and no requester waits more than NREQ−1 cycles.

## Structure
- Shared package `wb_pkg`:
  - `NREQ` default.
  - Requester index constants `WB_ALU`=0, `WB_LSU`=1, `WB_FPU`=2.
  - Packed typedef `wb_req_t` {rd[4:0], isf, data[31:0]}.
- Sub-module `rr_arbiter`, parameterised by N:
  - Inputs: `req`, `advance`.
  - Outputs: one-hot `gnt`.
  - Owns `ptr` and its asynchronous active-low reset.
- The top level holds the output register, x0 suppression and the contention counter.

## Test plan
- Reset asserted with `req_valid`=3'b111, then deasserted → while low, `req_ready`=0 and `RegWrite`=0. After release, the first grant goes to index 0.
- Continuous `req_valid`=3'b111 with rd=1,2,3 → `WriteReg` sequence 1,2,3,1,2,3 on consecutive cycles. `contention` increments every cycle.
- Only LSU valid, rd=7, data=32'hDEADBEEF, isf=0 → `req_ready`=3'b010 in the same cycle. The next cycle shows `RegWrite`=1, `WriteReg`=7, `WriteData`=32'hDEADBEEF, `writef`=0.
- ALU rd=0 isf=0, then FPU rd=0 isf=1 data=32'h3F800000 → the ALU request is accepted with `RegWrite`=0. The FPU write has `RegWrite`=1 and `writef`=1.
- `hold` high for 3 cycles with all requesters valid → `req_ready`=0 and `ptr` unchanged throughout. After release, the grant resumes at the pre-hold pointer.
- Force `contention` to 16'hFFFE, then 3 cycles of contention → the value saturates at 16'hFFFF.
